// File: rtl/prio_arb_pkg.sv
// Shared types, grant codes and small helpers for the 3-requester priority arbiter.
// Optional round-robin mode is selected with the PRIO_ARB_ROUND_ROBIN_EN macro.
package prio_arb_pkg;

   localparam int NREQ = 3;

   typedef enum logic {
      IDLE,
      GRANT
   } state_e;

   localparam logic [1:0] CODE_R0   = 2'b11;
   localparam logic [1:0] CODE_R1   = 2'b10;
   localparam logic [1:0] CODE_R2   = 2'b01;
   localparam logic [1:0] CODE_NONE = 2'b00;

   function automatic logic [NREQ-1:0] lowest_one(input logic [NREQ-1:0] v);
      logic [NREQ-1:0] r;
      r = '0;
      if (v[0])      r = 3'b001;
      else if (v[1]) r = 3'b010;
      else if (v[2]) r = 3'b100;
      return r;
   endfunction

   function automatic logic [1:0] gnt_to_code(input logic [NREQ-1:0] g);
      logic [1:0] c;
      case (g)
         3'b001:  c = CODE_R0;
         3'b010:  c = CODE_R1;
         3'b100:  c = CODE_R2;
         default: c = CODE_NONE;
      endcase
      return c;
   endfunction

   function automatic logic [1:0] gnt_to_idx(input logic [NREQ-1:0] g);
      logic [1:0] i;
      case (g)
         3'b010:  i = 2'd1;
         3'b100:  i = 2'd2;
         default: i = 2'd0;
      endcase
      return i;
   endfunction

endpackage

// File: rtl/prio_arbiter3_pick.sv
// Combinational one-hot picker: lowest-index (or rotated, with PRIO_ARB_ROUND_ROBIN_EN)
// set bit of req after masking out the excluded requesters.
module prio_pick3
   import prio_arb_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] excl,
`ifdef PRIO_ARB_ROUND_ROBIN_EN
   input  logic [1:0]      start,
`endif
   output logic [NREQ-1:0] pick
);

   logic [NREQ-1:0] cand;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
   logic [NREQ-1:0] rot;
   logic [NREQ-1:0] rot_pick;

   // Rotate so the start index sits at bit 0, take the lowest bit, rotate back.
   always_comb begin
      cand     = req & ~excl;
      rot      = cand;
      pick     = '0;
      case (start)
         2'd1:    rot = {cand[0], cand[2], cand[1]};
         2'd2:    rot = {cand[1], cand[0], cand[2]};
         default: rot = cand;
      endcase
      rot_pick = lowest_one(rot);
      case (start)
         2'd1:    pick = {rot_pick[1], rot_pick[0], rot_pick[2]};
         2'd2:    pick = {rot_pick[0], rot_pick[2], rot_pick[1]};
         default: pick = rot_pick;
      endcase
   end
`else
   always_comb begin
      cand = req & ~excl;
      pick = lowest_one(cand);
   end
`endif

endmodule

// File: rtl/prio_arbiter3.sv
// Registered 3-requester arbiter with grant hold and starvation timeout.
// Define PRIO_ARB_ROUND_ROBIN_EN to replace fixed priority with round-robin selection.
module prio_arbiter3
   import prio_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic [1:0]      gnt_code,
   output logic            busy,
   output logic            timeout
);

   state_e            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic              timeout_q, timeout_d;
   logic [NREQ-1:0]   pick;
   logic              owner_req;
   logic              others_req;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] start;

   assign start = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;

   prio_pick3 u_pick (
      .req   (req),
      .excl  (gnt_q),
      .start (start),
      .pick  (pick)
   );
`else
   prio_pick3 u_pick (
      .req   (req),
      .excl  (gnt_q),
      .pick  (pick)
   );
`endif

   assign owner_req  = |(req & gnt_q);
   assign others_req = |(req & ~gnt_q);

   // The current owner is always excluded from the pick, so pick is only
   // consumed on a fresh grant, a release hand-off or a timeout move.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;
      case (state_q)
         IDLE: begin
            hold_cnt_d = '0;
            if (|req) begin
               gnt_d   = pick;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               hold_cnt_d = '0;
               gnt_d      = pick;
               if (!others_req) state_d = IDLE;
            end else if (others_req) begin
               if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                  gnt_d      = pick;
                  timeout_d  = 1'b1;
                  hold_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + CNT_W'(1);
               end
            end else begin
               hold_cnt_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

`ifdef PRIO_ARB_ROUND_ROBIN_EN
   always_comb begin
      ptr_d = ptr_q;
      if ((|gnt_d) && (gnt_d != gnt_q)) ptr_d = gnt_to_idx(gnt_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= 2'd2;
      else        ptr_q <= ptr_d;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign gnt      = gnt_q;
   assign gnt_code = gnt_to_code(gnt_q);
   assign busy     = |gnt_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_prio_arbiter3.sv
// Directed self-checking bench for prio_arbiter3 (MAX_HOLD=16); expectations follow
// PRIO_ARB_ROUND_ROBIN_EN when the round-robin sequence is exercised.
module tb_prio_arbiter3;

   logic       clk;
   logic       rst_n;
   logic [2:0] req;
   logic [2:0] gnt;
   logic [1:0] gnt_code;
   logic       busy;
   logic       timeout;

   int checks   = 0;
   int failures = 0;

   prio_arbiter3 #(
      .MAX_HOLD (16),
      .CNT_W    (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .gnt      (gnt),
      .gnt_code (gnt_code),
      .busy     (busy),
      .timeout  (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive req, let n rising edges sample it, then settle 1 time unit past the edge.
   task automatic applyStimulus(input logic [2:0] r, input int n);
      req = r;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [2:0] eg, input logic [1:0] ec,
                              input logic eb, input logic et);
      checks++;
      assert (gnt === eg) else begin
         failures++;
         $error("FAIL %s gnt got=%b exp=%b", tag, gnt, eg);
      end
      checks++;
      assert (gnt_code === ec) else begin
         failures++;
         $error("FAIL %s gnt_code got=%b exp=%b", tag, gnt_code, ec);
      end
      checks++;
      assert (busy === eb) else begin
         failures++;
         $error("FAIL %s busy got=%b exp=%b", tag, busy, eb);
      end
      checks++;
      assert (timeout === et) else begin
         failures++;
         $error("FAIL %s timeout got=%b exp=%b", tag, timeout, et);
      end
   endtask

   task automatic doReset();
      req   = 3'b000;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [2:0] rr_exp [4];
      req   = 3'b000;
      rst_n = 1'b0;
      #2;
      checkOutput("reset", 3'b000, 2'b00, 1'b0, 1'b0);
      doReset();
      checkOutput("after_reset", 3'b000, 2'b00, 1'b0, 1'b0);

      $display("[TB] basic grant and hand-off");
      applyStimulus(3'b101, 1);
      checkOutput("grant_r0", 3'b001, 2'b11, 1'b1, 1'b0);
      applyStimulus(3'b100, 1);
      checkOutput("handoff_r2", 3'b100, 2'b01, 1'b1, 1'b0);
      applyStimulus(3'b000, 1);
      checkOutput("release_idle", 3'b000, 2'b00, 1'b0, 1'b0);

      $display("[TB] uncontended hold");
      applyStimulus(3'b010, 1);
      checkOutput("grant_r1", 3'b010, 2'b10, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) begin
         applyStimulus(3'b010, 1);
         checkOutput("hold_r1_alone", 3'b010, 2'b10, 1'b1, 1'b0);
      end

      $display("[TB] contended hold timeout");
      applyStimulus(3'b110, 15);
      checkOutput("contend_15", 3'b010, 2'b10, 1'b1, 1'b0);
      applyStimulus(3'b110, 1);
      checkOutput("timeout_move", 3'b100, 2'b01, 1'b1, 1'b1);
      applyStimulus(3'b110, 1);
      checkOutput("timeout_pulse_end", 3'b100, 2'b01, 1'b1, 1'b0);
      applyStimulus(3'b000, 1);
      checkOutput("idle_again", 3'b000, 2'b00, 1'b0, 1'b0);

      $display("[TB] no preemption");
      applyStimulus(3'b100, 1);
      checkOutput("grant_r2", 3'b100, 2'b01, 1'b1, 1'b0);
      applyStimulus(3'b101, 5);
      checkOutput("no_preempt", 3'b100, 2'b01, 1'b1, 1'b0);
      applyStimulus(3'b001, 1);
      checkOutput("r2_drop_to_r0", 3'b001, 2'b11, 1'b1, 1'b0);
      applyStimulus(3'b000, 1);
      checkOutput("idle_3", 3'b000, 2'b00, 1'b0, 1'b0);

      $display("[TB] asynchronous reset during grant");
      applyStimulus(3'b010, 1);
      checkOutput("pre_async", 3'b010, 2'b10, 1'b1, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 3'b000, 2'b00, 1'b0, 1'b0);
      #2;
      rst_n = 1'b1;
      applyStimulus(3'b010, 1);
      checkOutput("post_async", 3'b010, 2'b10, 1'b1, 1'b0);

      $display("[TB] repeated full-request bursts");
      doReset();
`ifdef PRIO_ARB_ROUND_ROBIN_EN
      rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
`else
      rr_exp[0] = 3'b001; rr_exp[1] = 3'b001; rr_exp[2] = 3'b001; rr_exp[3] = 3'b001;
`endif
      for (int i = 0; i < 4; i++) begin
         applyStimulus(3'b111, 1);
         checkOutput("burst_grant", rr_exp[i],
                     (rr_exp[i] == 3'b001) ? 2'b11 : (rr_exp[i] == 3'b010) ? 2'b10 : 2'b01,
                     1'b1, 1'b0);
         applyStimulus(3'b000, 1);
         checkOutput("burst_idle", 3'b000, 2'b00, 1'b0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
